dht11_uart_report: RTL and testbench

Formats the latest DHT11 humidity/temperature reading as a fixed ASCII report line and streams it byte by byte into the UART transmitter. It is the transmit-side counterpart of the UART command decoder: the decoder's report-request pulse starts a transfer, and this block drives the UART TX start/data handshake. It sits between the DHT11 sensor controller, the command decoder and the UART TX core.

---
 rtl/dht11_uart_report.sv | 109 ++++++++++
 tb/tb_dht11_uart_report.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dht11_uart_report.sv
// Streams the latest DHT11 reading as "H:hh T:tt" plus a line terminator
// into a UART TX core, one byte per tx_start/tx_busy handshake.
module dht11_uart_report #(
  parameter bit TERM_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       report_req,
  input  logic [7:0] humidity,
  input  logic [7:0] temperature,
  input  logic       data_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       done
);

  localparam int MSG_LEN = TERM_CRLF ? 11 : 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ACK,
    S_WAIT_IDLE,
    S_FINISH
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_idx;
  logic [7:0]  r_hum, r_temp;
  logic        r_valid;
  logic        w_accept, w_last, w_fire;
  logic [15:0] w_hdig, w_tdig;
  logic [7:0]  w_byte;

  // Two ASCII digits of a clamped 0..99 value, or "--" when there is no reading.
  function automatic logic [15:0] to_ascii(input logic [7:0] v, input logic ok);
    logic [6:0] c;
    c = (v > 8'd99) ? 7'd99 : v[6:0];
    if (!ok) return 16'h2D2D;
    return {8'h30 + 8'(c / 7'd10), 8'h30 + 8'(c % 7'd10)};
  endfunction

  assign w_accept = (r_state == S_IDLE) && report_req && sel;
  assign w_last   = (r_idx == 4'(MSG_LEN - 1));
  assign w_fire   = (r_state == S_LOAD) && !tx_busy;
  assign w_hdig   = to_ascii(r_hum, r_valid);
  assign w_tdig   = to_ascii(r_temp, r_valid);

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:  w_byte = 8'h48;
      4'd1:  w_byte = 8'h3A;
      4'd2:  w_byte = w_hdig[15:8];
      4'd3:  w_byte = w_hdig[7:0];
      4'd4:  w_byte = 8'h20;
      4'd5:  w_byte = 8'h54;
      4'd6:  w_byte = 8'h3A;
      4'd7:  w_byte = w_tdig[15:8];
      4'd8:  w_byte = w_tdig[7:0];
      4'd9:  w_byte = TERM_CRLF ? 8'h0D : 8'h0A;
      4'd10: w_byte = 8'h0A;
      default: w_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next = S_LOAD;
      S_LOAD:      if (!tx_busy) w_next = S_WAIT_ACK;
      S_WAIT_ACK:  if (tx_busy) w_next = S_WAIT_IDLE;
      S_WAIT_IDLE: if (!tx_busy) w_next = w_last ? S_FINISH : S_LOAD;
      S_FINISH:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= 4'd0;
      r_hum    <= 8'h00;
      r_temp   <= 8'h00;
      r_valid  <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      r_state  <= w_next;
      tx_start <= w_fire;
      if (w_fire) tx_data <= w_byte;
      if (w_accept) begin
        r_idx   <= 4'd0;
        r_hum   <= humidity;
        r_temp  <= temperature;
        r_valid <= data_valid;
      end else if (r_state == S_WAIT_IDLE && !tx_busy && !w_last) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_FINISH);

endmodule

// File: tb/tb_dht11_uart_report.sv
// Bench for dht11_uart_report: two instances (CRLF and LF-only) driven by a
// shared request, each with its own UART TX busy model and byte log.
module tb_dht11_uart_report;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      sel = 2'b00;
  logic            report_req = 1'b0;
  logic [7:0]      humidity = 8'd0, temperature = 8'd0;
  logic            data_valid = 1'b0;
  logic [1:0]      txb = 2'b00;
  logic [1:0][7:0] txd;
  logic [1:0]      txs, bsy, dn;

  always #5 clk = ~clk;

  dht11_uart_report #(.TERM_CRLF(1'b0)) u_lf (
    .clk(clk), .rst(rst), .sel(sel[0]), .report_req(report_req),
    .humidity(humidity), .temperature(temperature), .data_valid(data_valid),
    .tx_busy(txb[0]), .tx_data(txd[0]), .tx_start(txs[0]), .busy(bsy[0]), .done(dn[0]));

  dht11_uart_report #(.TERM_CRLF(1'b1)) u_crlf (
    .clk(clk), .rst(rst), .sel(sel[1]), .report_req(report_req),
    .humidity(humidity), .temperature(temperature), .data_valid(data_valid),
    .tx_busy(txb[1]), .tx_data(txd[1]), .tx_start(txs[1]), .busy(bsy[1]), .done(dn[1]));

  int n_cmp = 0, n_err = 0;
  int cyc = 0, blen = 20;
  int busy_cnt[2], starts[2], dones[2], viol[2], fall_cyc[2], done_cyc[2];
  logic [7:0] q0[$], q1[$], expq[$];

  // UART TX model: stays busy blen cycles after each tx_start; logs bytes and events.
  initial begin
    for (int u = 0; u < 2; u++) begin
      busy_cnt[u] = 0; starts[u] = 0; dones[u] = 0; viol[u] = 0;
      fall_cyc[u] = 0; done_cyc[u] = 0;
    end
    forever begin
      @(posedge clk); #1;
      cyc++;
      for (int u = 0; u < 2; u++) begin
        if (busy_cnt[u] > 0) begin
          busy_cnt[u]--;
          if (busy_cnt[u] == 0) begin txb[u] = 1'b0; fall_cyc[u] = cyc; end
        end
        if (txs[u]) begin
          if (txb[u]) viol[u]++;
          if (u == 1) q1.push_back(txd[1]); else q0.push_back(txd[0]);
          starts[u]++;
          txb[u] = 1'b1;
          busy_cnt[u] = blen;
        end
        if (dn[u]) begin dones[u]++; done_cyc[u] = cyc; end
      end
    end
  end

  task automatic push_digits(input int v, input bit ok);
    int c;
    c = (v > 99) ? 99 : v;
    if (!ok) begin expq.push_back(8'h2D); expq.push_back(8'h2D); end
    else begin expq.push_back(8'(48 + c / 10)); expq.push_back(8'(48 + c % 10)); end
  endtask

  task automatic build(input int h, input int t, input bit ok, input bit crlf);
    expq.delete();
    expq.push_back("H"); expq.push_back(":");
    push_digits(h, ok);
    expq.push_back(" "); expq.push_back("T"); expq.push_back(":");
    push_digits(t, ok);
    if (crlf) expq.push_back(8'h0D);
    expq.push_back(8'h0A);
  endtask

  // Sends one request to unit u and checks the whole transfer. req_at / chg_at
  // (cycles after acceptance, -1 = never) inject a repeat request or input change.
  task automatic do_msg(input int u, input int h, input int t, input bit ok, input int bl,
                        input string name, input int req_at, input int chg_at);
    int qb, sb, db, k, got_n;
    logic [7:0] g;
    blen = bl;
    build(h, t, ok, u == 1);
    qb = (u == 1) ? q1.size() : q0.size();
    sb = starts[u]; db = dones[u];
    @(negedge clk);
    humidity = 8'(h); temperature = 8'(t); data_valid = ok;
    sel[u] = 1'b1; report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0; sel = 2'b00;
    n_cmp++;
    if (bsy[u] !== 1'b1) begin n_err++; $display("FAIL %s busy after accept: got %b want 1", name, bsy[u]); end
    k = 0;
    while (dones[u] == db && k < 5000) begin
      @(negedge clk); k++;
      report_req = 1'b0; sel = 2'b00;
      if (k == req_at) begin sel[u] = 1'b1; report_req = 1'b1; end
      if (k == chg_at) begin humidity = ~humidity; temperature = temperature + 8'd3; data_valid = ~data_valid; end
    end
    report_req = 1'b0; sel = 2'b00;
    n_cmp++;
    if (dones[u] == db) begin
      n_err++; $display("FAIL %s done timeout: got no done within %0d cycles, want one", name, k);
      return;
    end
    @(negedge clk);
    n_cmp++;
    if (bsy[u] !== 1'b0 || dn[u] !== 1'b0) begin
      n_err++; $display("FAIL %s after done: busy=%b done=%b want 0 0", name, bsy[u], dn[u]);
    end
    got_n = ((u == 1) ? q1.size() : q0.size()) - qb;
    n_cmp++;
    if (got_n != expq.size()) begin n_err++; $display("FAIL %s byte count: got %0d want %0d", name, got_n, expq.size()); end
    for (int i = 0; i < expq.size() && i < got_n; i++) begin
      g = (u == 1) ? q1[qb + i] : q0[qb + i];
      n_cmp++;
      if (g !== expq[i]) begin n_err++; $display("FAIL %s byte %0d: got %h want %h", name, i, g, expq[i]); end
    end
    n_cmp++;
    if (starts[u] - sb != expq.size()) begin n_err++; $display("FAIL %s tx_start count: got %0d want %0d", name, starts[u] - sb, expq.size()); end
    n_cmp++;
    if (dones[u] - db != 1) begin n_err++; $display("FAIL %s done pulses: got %0d want 1", name, dones[u] - db); end
    n_cmp++;
    if (done_cyc[u] != fall_cyc[u] + 1) begin n_err++; $display("FAIL %s done timing: got cycle %0d want %0d", name, done_cyc[u], fall_cyc[u] + 1); end
    n_cmp++;
    if (viol[u] != 0) begin n_err++; $display("FAIL %s tx_start while busy: got %0d want 0", name, viol[u]); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if (txs[u] !== 1'b0 || txd[u] !== 8'h00 || bsy[u] !== 1'b0 || dn[u] !== 1'b0) begin
        n_err++; $display("FAIL reset u%0d: start=%b data=%h busy=%b done=%b want 0 00 0 0", u, txs[u], txd[u], bsy[u], dn[u]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sel_low();
    int s0, s1;
    s0 = starts[0]; s1 = starts[1];
    @(negedge clk); humidity = 8'd12; data_valid = 1'b1; sel = 2'b00; report_req = 1'b1;
    @(negedge clk); report_req = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (starts[0] != s0 || starts[1] != s1 || bsy !== 2'b00) begin
      n_err++; $display("FAIL sel_low: starts=%0d/%0d busy=%b want %0d/%0d 00", starts[0], starts[1], bsy, s0, s1);
    end
  endtask

  task automatic test_rst_mid();
    int sb, k;
    blen = 10;
    sb = starts[1];
    @(negedge clk); humidity = 8'd33; temperature = 8'd44; data_valid = 1'b1; sel[1] = 1'b1; report_req = 1'b1;
    @(negedge clk); report_req = 1'b0; sel = 2'b00;
    k = 0;
    while (starts[1] - sb < 5 && k < 2000) begin @(negedge clk); k++; end
    n_cmp++;
    if (starts[1] - sb < 5) begin n_err++; $display("FAIL rst_mid byte4 timeout: got %0d starts want 5", starts[1] - sb); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (txs[1] !== 1'b0 || txd[1] !== 8'h00 || bsy[1] !== 1'b0 || dn[1] !== 1'b0) begin
      n_err++; $display("FAIL rst_mid outputs: start=%b data=%h busy=%b done=%b want 0 00 0 0", txs[1], txd[1], bsy[1], dn[1]);
    end
    @(negedge clk); rst = 1'b0;
    sb = starts[1];
    k = 0;
    while (txb[1] && k < 100) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (starts[1] != sb || bsy[1] !== 1'b0) begin
      n_err++; $display("FAIL rst_mid idle after reset: starts delta %0d busy=%b want 0 0", starts[1] - sb, bsy[1]);
    end
    do_msg(1, 61, 18, 1'b1, 4, "rst_mid_resend", -1, -1);
  endtask

  task automatic test_random();
    int h, t, bl;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      h = $urandom_range(0, 255); t = $urandom_range(0, 255);
      ok = ($urandom_range(0, 3) != 0); bl = $urandom_range(1, 8);
      do_msg(i % 2, h, t, ok, bl, "random", -1, -1);
    end
  endtask

  initial begin
    test_reset();
    do_msg(1, 45, 23, 1'b1, 20, "basic", -1, -1);
    do_msg(1, 7, 150, 1'b1, 5, "clamp", -1, -1);
    do_msg(1, 88, 12, 1'b0, 3, "invalid", -1, -1);
    do_msg(0, 45, 23, 1'b1, 6, "lf_only", -1, -1);
    test_sel_low();
    do_msg(1, 52, 9, 1'b1, 6, "req_mid", 40, -1);
    repeat (200) @(negedge clk);
    n_cmp++;
    if (bsy[1] !== 1'b0) begin n_err++; $display("FAIL req_mid queued: busy=%b want 0", bsy[1]); end
    do_msg(1, 99, 100, 1'b1, 4, "snapshot", -1, 20);
    do_msg(0, 0, 255, 1'b1, 1, "lf_edge", -1, 15);
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
